// File: rtl/wb_mux_pipe.sv
// Pipelined write-back source selector with a 2-entry skid buffer and registered outputs.
// Define WBMUX_LOADEXT_EN to enable lb/lbu/lh/lhu extraction on the memory-data source.
module wb_mux_pipe #(
   parameter int WIDTH   = 32,
   parameter int NUM_IN  = 5,
   parameter int SEL_W   = 3,
   parameter int MEM_IDX = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] data_in,
   input  logic [1:0]              ld_size,
   input  logic                    ld_unsigned,
   input  logic [1:0]              byte_off,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    sel_err,
   output logic [7:0]              err_count
);

   logic [WIDTH-1:0] src [NUM_IN];
   logic [WIDTH-1:0] pick_next;
   logic             err_next;
   logic [WIDTH-1:0] result_next;

   generate
      for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_src
         assign src[gi] = data_in[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Out-of-range selects fall through to zero with the error flag set.
   always_comb begin
      pick_next = '0;
      err_next  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            pick_next = src[k];
            err_next  = 1'b0;
         end
      end
   end

`ifdef WBMUX_LOADEXT_EN
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      result_next = pick_next;
      lane_b      = pick_next[{byte_off, 3'b000} +: 8];
      lane_h      = pick_next[{byte_off[1], 4'b0000} +: 16];
      if (!err_next && sel == SEL_W'(MEM_IDX)) begin
         if (ld_size == 2'b10) begin
            result_next = {{(WIDTH-8){~ld_unsigned & lane_b[7]}}, lane_b};
         end else if (ld_size == 2'b01) begin
            result_next = {{(WIDTH-16){~ld_unsigned & lane_h[15]}}, lane_h};
         end
      end
   end
`else
   logic unused_ld;
   assign unused_ld   = ^{ld_size, ld_unsigned, byte_off};
   assign result_next = pick_next;
`endif

   logic             main_valid_reg;
   logic [WIDTH-1:0] main_data_reg;
   logic             main_err_reg;
   logic             skid_valid_reg;
   logic [WIDTH-1:0] skid_data_reg;
   logic             skid_err_reg;
   logic [7:0]       err_count_reg;
   logic             accept;
   logic             xfer;

   assign in_ready  = ~skid_valid_reg;
   assign accept    = in_valid & in_ready;
   assign xfer      = main_valid_reg & out_ready;
   assign out_valid = main_valid_reg;
   assign out_data  = main_data_reg;
   assign sel_err   = main_err_reg;
   assign err_count = err_count_reg;

   // The skid entry only fills while main is stalled, so skid full implies main full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_reg <= 1'b0;
         main_data_reg  <= '0;
         main_err_reg   <= 1'b0;
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
         skid_err_reg   <= 1'b0;
      end else if (skid_valid_reg) begin
         if (xfer) begin
            main_data_reg  <= skid_data_reg;
            main_err_reg   <= skid_err_reg;
            skid_valid_reg <= 1'b0;
         end
      end else if (!main_valid_reg || xfer) begin
         main_valid_reg <= accept;
         if (accept) begin
            main_data_reg <= result_next;
            main_err_reg  <= err_next;
         end
      end else if (accept) begin
         skid_valid_reg <= 1'b1;
         skid_data_reg  <= result_next;
         skid_err_reg   <= err_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_reg <= 8'd0;
      end else if (accept && err_next && err_count_reg != 8'hFF) begin
         err_count_reg <= err_count_reg + 8'd1;
      end
   end

endmodule

// File: tb/tb_wb_mux_pipe.sv
// Self-checking bench for wb_mux_pipe: queue-based reference model plus directed and random scenarios.
module tb_wb_mux_pipe;

   localparam int WIDTH = 32;
   localparam int NUM_IN = 5;
   localparam int SEL_W = 3;
   localparam int MEM_IDX = 1;

   logic                    clk;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        sel;
   logic [NUM_IN*WIDTH-1:0] data_in;
   logic [1:0]              ld_size;
   logic                    ld_unsigned;
   logic [1:0]              byte_off;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    sel_err;
   logic [7:0]              err_count;

   wb_mux_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .MEM_IDX(MEM_IDX)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
      .data_in(data_in), .ld_size(ld_size), .ld_unsigned(ld_unsigned), .byte_off(byte_off),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sel_err(sel_err),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } beat_t;

   beat_t q[$];
   int    exp_cnt = 0;
   int    tests_run = 0;
   int    tests_failed = 0;

   // Reference result computed from the selection / load-extension rules with plain arithmetic.
   function automatic beat_t model_result();
      beat_t b;
      logic [31:0] w;
      int unsigned v;
      b.err = 1'b0;
      if (int'(sel) >= NUM_IN) begin
         b.data = 32'h0;
         b.err  = 1'b1;
         return b;
      end
      w = data_in[int'(sel)*WIDTH +: WIDTH];
      b.data = w;
`ifdef WBMUX_LOADEXT_EN
      if (int'(sel) == MEM_IDX && ld_size == 2'd2) begin
         v = (w >> (8 * int'(byte_off))) & 32'hFF;
         if (!ld_unsigned && v >= 128) v = v + 32'hFFFFFF00;
         b.data = v;
      end else if (int'(sel) == MEM_IDX && ld_size == 2'd1) begin
         v = (w >> (byte_off[1] ? 16 : 0)) & 32'hFFFF;
         if (!ld_unsigned && v >= 32768) v = v + 32'hFFFF0000;
         b.data = v;
      end
`endif
      return b;
   endfunction

   // Advances one clock and updates the model (entries in flight = queue depth, capacity 2).
   task automatic step();
      beat_t b;
      bit xfer, acc;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         exp_cnt = 0;
      end else begin
         b    = model_result();
         xfer = (q.size() > 0) && out_ready;
         acc  = in_valid && (q.size() < 2);
         if (xfer) void'(q.pop_front());
         if (acc) begin
            q.push_back(b);
            if (b.err && exp_cnt < 255) exp_cnt++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = '0; data_in = '0;
      ld_size = 2'd0; ld_unsigned = 1'b0; byte_off = 2'd0;
      step();
      step();
      tests_run++;
      if ({out_valid, in_ready, out_data, sel_err, err_count} !== {1'b0, 1'b1, 32'h0, 1'b0, 8'h0}) begin
         tests_failed++;
         $display("FAIL reset: valid=%0b ready=%0b data=%h err=%0b cnt=%0d required 0 1 0 0 0",
                  out_valid, in_ready, out_data, sel_err, err_count);
      end
      rst_n = 1'b1;
      step();
      $display("[TB] reset released");
   endtask

   task automatic test_passthrough();
      data_in = '0;
      data_in[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
      sel = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || in_ready !== 1'b1 || sel_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL passthrough[%0d]: valid=%0b data=%h ready=%0b err=%0b required 1 deadbeef 1 0",
                     i, out_valid, out_data, in_ready, sel_err);
         end
         $display("[TB] passthrough beat %0d data=%h", i, out_data);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      logic [31:0] seen [4];
      logic [31:0] req [4];
      req[0] = 32'h11; req[1] = 32'h11; req[2] = 32'h22; req[3] = 32'h0;
      out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0;
      data_in[31:0] = 32'h11; step();
      data_in[31:0] = 32'h22; step();
      in_valid = 1'b0;
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11) begin
         tests_failed++;
         $display("FAIL bp_full: ready=%0b valid=%0b data=%h required 0 1 11", in_ready, out_valid, out_data);
      end
      step();
      seen[0] = out_data;
      out_ready = 1'b1;
      seen[1] = out_data;
      step();
      seen[2] = out_data;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_ready_return: ready=%0b required 1", in_ready);
      end
      step();
      seen[3] = out_valid ? out_data : 32'h0;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (seen[i] !== req[i]) begin
            tests_failed++;
            $display("FAIL bp_order[%0d]: got %h required %h", i, seen[i], req[i]);
         end
         $display("[TB] backpressure sample %0d data=%h", i, seen[i]);
      end
   endtask

   task automatic test_random();
      bit exp_v, exp_r;
      for (int i = 0; i < 400; i++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         sel         = ($urandom_range(0, 9) == 0) ? SEL_W'($urandom_range(5, 7)) : SEL_W'($urandom_range(0, 4));
         for (int k = 0; k < NUM_IN; k++) data_in[k*WIDTH +: WIDTH] = $urandom;
         ld_size     = 2'($urandom_range(0, 3));
         ld_unsigned = 1'($urandom_range(0, 1));
         byte_off    = 2'($urandom_range(0, 3));
         step();
         exp_v = (q.size() > 0);
         exp_r = (q.size() < 2);
         tests_run++;
         if (out_valid !== exp_v || in_ready !== exp_r || err_count !== 8'(exp_cnt) ||
             (exp_v && (out_data !== q[0].data || sel_err !== q[0].err))) begin
            tests_failed++;
            $display("FAIL random[%0d]: valid=%0b ready=%0b data=%h err=%0b cnt=%0d required %0b %0b %h %0b %0d",
                     i, out_valid, in_ready, out_data, sel_err, err_count, exp_v, exp_r,
                     exp_v ? q[0].data : 32'h0, exp_v ? q[0].err : 1'b0, exp_cnt);
         end
         $display("[TB] random %0d valid=%0b data=%h cnt=%0d", i, out_valid, out_data, err_count);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
   endtask

   task automatic test_sel_err();
      int bad = 0;
      in_valid = 1'b1; out_ready = 1'b1; sel = 3'd5;
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < NUM_IN; k++) data_in[k*WIDTH +: WIDTH] = $urandom | 32'h1;
         step();
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== 32'h0 || sel_err !== 1'b1 || err_count !== 8'(exp_cnt)) begin
            tests_failed++;
            bad++;
            if (bad < 5)
               $display("FAIL sel_err[%0d]: valid=%0b data=%h err=%0b cnt=%0d required 1 0 1 %0d",
                        i, out_valid, out_data, sel_err, err_count, exp_cnt);
         end
      end
      in_valid = 1'b0;
      step();
      tests_run++;
      if (err_count !== 8'd255) begin
         tests_failed++;
         $display("FAIL err_saturate: cnt=%0d required 255", err_count);
      end
      $display("[TB] sel_err burst done cnt=%0d", err_count);
   endtask

   task automatic test_loadext();
      logic [1:0]  sz [4];
      logic        un [4];
      logic [1:0]  off [4];
      logic [31:0] req [4];
      sz[0] = 2'd2; un[0] = 1'b0; off[0] = 2'd0;
      sz[1] = 2'd2; un[1] = 1'b1; off[1] = 2'd2;
      sz[2] = 2'd1; un[2] = 1'b0; off[2] = 2'd2;
      sz[3] = 2'd0; un[3] = 1'b0; off[3] = 2'd0;
`ifdef WBMUX_LOADEXT_EN
      req[0] = 32'hFFFFFFA5; req[1] = 32'h00000070; req[2] = 32'hFFFF8070; req[3] = 32'h8070F0A5;
`else
      req[0] = 32'h8070F0A5; req[1] = 32'h8070F0A5; req[2] = 32'h8070F0A5; req[3] = 32'h8070F0A5;
`endif
      data_in = '0;
      data_in[MEM_IDX*WIDTH +: WIDTH] = 32'h8070F0A5;
      sel = 3'(MEM_IDX); out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ld_size = sz[i]; ld_unsigned = un[i]; byte_off = off[i];
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== req[i] || sel_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL loadext[%0d]: valid=%0b data=%h err=%0b required 1 %h 0",
                     i, out_valid, out_data, sel_err, req[i]);
         end
         $display("[TB] loadext case %0d data=%h", i, out_data);
         step();
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0;
      data_in[31:0] = 32'hAA; step();
      data_in[31:0] = 32'hBB; step();
      in_valid = 1'b0;
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_full: ready=%0b valid=%0b required 0 1", in_ready, out_valid);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || err_count !== 8'h0) begin
         tests_failed++;
         $display("FAIL rstmid_async: valid=%0b ready=%0b data=%h cnt=%0d required 0 1 0 0",
                  out_valid, in_ready, out_data, err_count);
      end
      @(negedge clk);
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_stale[%0d]: valid=%0b ready=%0b data=%h required 0 1", i, out_valid, in_ready, out_data);
         end
         $display("[TB] post-reset cycle %0d valid=%0b", i, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_backpressure();
      test_random();
      test_sel_err();
      test_loadext();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
